// File: rtl/qam32_map_pkg.sv
// Shared constants and types for the 32QAM mapper controller.
// QAM32_MAP_FLUSH_EN (top) enables short-group flush via BitInLast.
package qam32_map_pkg;

  localparam int BITS_PER_SYM   = 5;
  localparam int IM_ADDR_OFFSET = 32;
  localparam int DATA_W_DEF     = 12;

  typedef enum logic {
    COLLECT,
    STALL
  } state_t;

endpackage

// File: rtl/qam32_sym_fifo.sv
// First-word-fall-through symbol FIFO with occupancy count.
// Head reads as zero while empty so idle outputs stay clean.
module qam32_sym_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_eff;
  logic          full;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_eff = pop && valid;
  assign rdata   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop_eff)      count <= count + 1'b1;
      else if (!push && pop_eff) count <= count - 1'b1;
    end
  end

  // Credit accounting upstream guarantees a free slot for every push.
  overflow_chk: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && full && !pop_eff)
  );

endmodule

// File: rtl/qam32_map_ctrl.sv
// 32QAM ROM sequencing: bit packing, credit-gated issue, FWFT output.
// QAM32_MAP_FLUSH_EN adds BitInLast to close a short group early.
module qam32_map_ctrl
  import qam32_map_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ROM_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_SYMS = 64
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              BitIn,
  input  logic              BitInValid,
`ifdef QAM32_MAP_FLUSH_EN
  input  logic              BitInLast,
`endif
  output logic              BitInReady,
  output logic [5:0]        RomAddrRe,
  output logic [5:0]        RomAddrIm,
  input  logic [DATA_W-1:0] RomDoutRe,
  input  logic [DATA_W-1:0] RomDoutIm,
  output logic [DATA_W-1:0] SymRe,
  output logic [DATA_W-1:0] SymIm,
  output logic              SymValid,
  input  logic              SymReady,
  output logic              SymLast,
  output logic              Busy
);

  localparam int SW = (FRAME_SYMS > 1) ? $clog2(FRAME_SYMS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  state_t          state;
  logic [3:0]      sh;
  logic [2:0]      bit_cnt;
  logic [4:0]      pend_idx;
  logic [SW-1:0]   sym_idx;
  logic [ROM_LAT:0] vld;
  logic [ROM_LAT:0] lst;
  logic [AW:0]     fifo_cnt;
  logic [AW+1:0]   inflight;
  logic            flush;
  logic            xfer;
  logic            done;
  logic            credit;
  logic            issue;
  logic            is_last;
  logic [4:0]      cat;
  logic [4:0]      new_idx;
  logic [4:0]      iss_idx;

`ifdef QAM32_MAP_FLUSH_EN
  assign flush = BitInLast;
`else
  assign flush = 1'b0;
`endif

  assign BitInReady = (state == COLLECT);
  assign xfer    = BitInValid && BitInReady;
  assign done    = xfer && ((bit_cnt == 3'd4) || flush);
  assign cat     = {sh, BitIn};
  // Short groups are left-aligned so missing LSBs read as zero.
  assign new_idx = cat << (3'd4 - bit_cnt);
  assign iss_idx = (state == STALL) ? pend_idx : new_idx;
  assign is_last = (sym_idx == SW'(FRAME_SYMS - 1));

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= ROM_LAT; i++)
      inflight = inflight + {{(AW+1){1'b0}}, vld[i]};
  end

  assign credit = ({1'b0, fifo_cnt} + inflight) < (AW+2)'(FIFO_DEPTH);
  assign issue  = credit && ((state == STALL) || done);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= COLLECT;
      sh        <= '0;
      bit_cnt   <= '0;
      pend_idx  <= '0;
      RomAddrRe <= '0;
      RomAddrIm <= 6'(IM_ADDR_OFFSET);
      sym_idx   <= '0;
      vld       <= '0;
      lst       <= '0;
    end else begin
      vld <= {vld[ROM_LAT-1:0], issue};
      lst <= {lst[ROM_LAT-1:0], issue && is_last};
      if (xfer) begin
        if (done) begin
          sh      <= '0;
          bit_cnt <= '0;
        end else begin
          sh      <= {sh[2:0], BitIn};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (issue) begin
        RomAddrRe <= {1'b0, iss_idx};
        RomAddrIm <= {1'b1, iss_idx};
        sym_idx   <= is_last ? '0 : sym_idx + 1'b1;
      end
      unique case (state)
        COLLECT: begin
          if (done && !credit) begin
            state    <= STALL;
            pend_idx <= new_idx;
          end
        end
        STALL: begin
          if (credit) state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

  qam32_sym_fifo #(
    .W     (2*DATA_W+1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (Rst_n),
    .push  (vld[ROM_LAT]),
    .wdata ({RomDoutRe, RomDoutIm, lst[ROM_LAT]}),
    .pop   (SymReady),
    .rdata ({SymRe, SymIm, SymLast}),
    .valid (SymValid),
    .count (fifo_cnt)
  );

  assign Busy = (bit_cnt != '0) || (state == STALL) || (|vld) || SymValid;

endmodule

// File: tb/tb_qam32_map_ctrl.sv
// Bench for qam32_map_ctrl: vector table, corner sequences, random traffic.
// Symbol scoreboard is built from bit groups and a ROM lookup function.
module tb_qam32_map_ctrl;

  localparam int DW = 12;
  localparam int FS = 8;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b1;
  logic          BitIn = 1'b0;
  logic          BitInValid = 1'b0;
  logic          SymReady = 1'b0;
`ifdef QAM32_MAP_FLUSH_EN
  logic          BitInLast = 1'b0;
`endif
  logic          BitInReady;
  logic [5:0]    RomAddrRe;
  logic [5:0]    RomAddrIm;
  logic [DW-1:0] RomDoutRe;
  logic [DW-1:0] RomDoutIm;
  logic [DW-1:0] SymRe;
  logic [DW-1:0] SymIm;
  logic          SymValid;
  logic          SymLast;
  logic          Busy;

  always #5 Clk = ~Clk;

  qam32_map_ctrl #(
    .DATA_W     (DW),
    .ROM_LAT    (1),
    .FIFO_DEPTH (4),
    .FRAME_SYMS (FS)
  ) u_dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .BitIn      (BitIn),
    .BitInValid (BitInValid),
`ifdef QAM32_MAP_FLUSH_EN
    .BitInLast  (BitInLast),
`endif
    .BitInReady (BitInReady),
    .RomAddrRe  (RomAddrRe),
    .RomAddrIm  (RomAddrIm),
    .RomDoutRe  (RomDoutRe),
    .RomDoutIm  (RomDoutIm),
    .SymRe      (SymRe),
    .SymIm      (SymIm),
    .SymValid   (SymValid),
    .SymReady   (SymReady),
    .SymLast    (SymLast),
    .Busy       (Busy)
  );

  function automatic logic [DW-1:0] rom_re_f(logic [5:0] a);
    return DW'(int'(a) * 73 + 341);
  endfunction

  function automatic logic [DW-1:0] rom_im_f(logic [5:0] a);
    return DW'((int'(a) * 211) ^ 'hA5C);
  endfunction

  // Dual-port ROM with one cycle of read latency.
  always @(posedge Clk) begin
    RomDoutRe <= rom_re_f(RomAddrRe);
    RomDoutIm <= rom_im_f(RomAddrIm);
  end

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } sym_t;

  typedef struct {
    logic [4:0] bits;
    logic [5:0] are;
    logic [5:0] aim;
  } vec_t;

  sym_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   acc = 0;
  int   nbits = 0;
  int   nsym = 0;
  int   pops = 0;
  int   xfers = 0;
  int   nlast = 0;
  logic last_xfer = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic model_bit(input logic b, input logic lb);
    sym_t s;
    logic [4:0] idx;
    acc = acc * 2 + int'(b);
    nbits++;
    if (nbits == 5 || lb) begin
      idx    = 5'(acc << (5 - nbits));
      s.re   = rom_re_f({1'b0, idx});
      s.im   = rom_im_f(6'(32 + int'(idx)));
      s.last = ((nsym % FS) == FS - 1);
      exp_q.push_back(s);
      nsym++;
      acc   = 0;
      nbits = 0;
    end
  endtask

  task automatic step();
    logic x;
    logic p;
    logic lb;
    sym_t e;
    #1;
    x  = BitInValid && BitInReady;
    p  = SymValid && SymReady;
    lb = 1'b0;
`ifdef QAM32_MAP_FLUSH_EN
    lb = BitInLast;
`endif
    if (p) begin
      pops++;
      if (SymLast) nlast++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sym_re", 32'(SymRe), 32'(e.re));
        chk("sym_im", 32'(SymIm), 32'(e.im));
        chk("sym_last", 32'(SymLast), 32'(e.last));
      end
    end
    last_xfer = x;
    if (x) begin
      xfers++;
      model_bit(BitIn, lb);
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic feed_bit(input logic b);
    int n;
    BitIn = b;
    BitInValid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_xfer && n < 100);
    if (!last_xfer) chk("bit_timeout", 0, 1);
  endtask

  task automatic feed5(input logic [4:0] v);
    for (int j = 4; j >= 0; j--) feed_bit(v[j]);
    BitInValid = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n;
    SymReady = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || SymValid) && n < lim) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset(input logic check);
    BitInValid = 1'b0;
    SymReady = 1'b0;
    Rst_n = 1'b0;
    #1;
    if (check) begin
      chk("rst_ready", 32'(BitInReady), 1);
      chk("rst_addr_re", 32'(RomAddrRe), 0);
      chk("rst_addr_im", 32'(RomAddrIm), 32);
      chk("rst_sym_re", 32'(SymRe), 0);
      chk("rst_sym_im", 32'(SymIm), 0);
      chk("rst_valid", 32'(SymValid), 0);
      chk("rst_last", 32'(SymLast), 0);
      chk("rst_busy", 32'(Busy), 0);
    end
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    acc = 0;
    nbits = 0;
    nsym = 0;
    exp_q.delete();
  endtask

  initial begin
    vec_t tbl[5];
    logic bp[50];
    int   p0;
    int   x0;
    int   l0;
    int   pos;
    int   n;

    tbl[0] = '{5'b00000, 6'd0,  6'd32};
    tbl[1] = '{5'b11111, 6'd31, 6'd63};
    tbl[2] = '{5'b10101, 6'd21, 6'd53};
    tbl[3] = '{5'b01100, 6'd12, 6'd44};
    tbl[4] = '{5'b00001, 6'd1,  6'd33};

    #2;
    do_reset(1'b1);

    // Mapping and latency per table entry.
    for (int i = 0; i < 5; i++) begin
      SymReady = 1'b1;
      feed5(tbl[i].bits);
      chk("tbl_addr_re", 32'(RomAddrRe), 32'(tbl[i].are));
      chk("tbl_addr_im", 32'(RomAddrIm), 32'(tbl[i].aim));
      chk("tbl_lat0", 32'(SymValid), 0);
      step();
      chk("tbl_lat1", 32'(SymValid), 0);
      step();
      chk("tbl_lat2", 32'(SymValid), 1);
      step();
      chk("tbl_popped", 32'(SymValid), 0);
    end

    // Backpressure: 40 stalled cycles with 50 bits on offer.
    do_reset(1'b0);
    for (int i = 0; i < 50; i++) bp[i] = 1'($urandom_range(0, 1));
    pos = 0;
    x0 = xfers;
    p0 = pops;
    for (int c = 0; c < 40; c++) begin
      BitInValid = (pos < 50);
      BitIn = bp[pos < 50 ? pos : 0];
      step();
      if (last_xfer) pos++;
    end
    chk("bp_accepted", 32'(xfers - x0), 25);
    chk("bp_ready_low", 32'(BitInReady), 0);
    chk("bp_fifo_full", 32'(u_dut.u_fifo.count), 4);
    SymReady = 1'b1;
    n = 0;
    while (pos < 50 && n < 200) begin
      BitInValid = 1'b1;
      BitIn = bp[pos];
      step();
      if (last_xfer) pos++;
      n++;
    end
    BitInValid = 1'b0;
    drain(40);
    chk("bp_pop_count", 32'(pops - p0), 10);

    // Full FIFO with pending index: single-cycle pop.
    do_reset(1'b0);
    feed5(5'd3);
    feed5(5'd7);
    feed5(5'd11);
    feed5(5'd19);
    feed5(5'd26);
    step();
    step();
    step();
    chk("ff_stalled", 32'(BitInReady), 0);
    chk("ff_addr_hold", 32'(RomAddrRe), 19);
    p0 = pops;
    SymReady = 1'b1;
    step();
    SymReady = 1'b0;
    chk("ff_no_early", 32'(RomAddrRe), 19);
    step();
    chk("ff_pend_re", 32'(RomAddrRe), 26);
    chk("ff_pend_im", 32'(RomAddrIm), 58);
    chk("ff_ready_back", 32'(BitInReady), 1);
    chk("ff_one_pop", 32'(pops - p0), 1);
    step();
    step();
    chk("ff_refull", 32'(u_dut.u_fifo.count), 4);
    drain(20);

    // Frame tagging over two frames.
    do_reset(1'b0);
    SymReady = 1'b1;
    p0 = pops;
    l0 = nlast;
    for (int i = 0; i < 16; i++) feed5(5'($urandom_range(0, 31)));
    drain(20);
    chk("frame_pops", 32'(pops - p0), 16);
    chk("frame_lasts", 32'(nlast - l0), 2);

    // Reset with a partial group and two queued symbols.
    do_reset(1'b0);
    feed5(5'd9);
    feed5(5'd17);
    feed_bit(1'b1);
    feed_bit(1'b0);
    feed_bit(1'b1);
    BitInValid = 1'b0;
    step();
    step();
    chk("mid_queued", 32'(u_dut.u_fifo.count), 2);
    do_reset(1'b1);
    SymReady = 1'b1;
    feed5(5'b10101);
    chk("mid_addr_re", 32'(RomAddrRe), 21);
    chk("mid_addr_im", 32'(RomAddrIm), 53);
    chk("mid_symidx", 32'(u_dut.sym_idx), 1);
    drain(10);

`ifdef QAM32_MAP_FLUSH_EN
    do_reset(1'b0);
    SymReady = 1'b1;
    feed_bit(1'b1);
    BitInLast = 1'b1;
    feed_bit(1'b1);
    BitInLast = 1'b0;
    BitInValid = 1'b0;
    chk("flush_re", 32'(RomAddrRe), 24);
    chk("flush_im", 32'(RomAddrIm), 56);
    feed5(5'b00111);
    chk("flush_next", 32'(RomAddrRe), 7);
    drain(10);
`endif

    // Random traffic against the scoreboard.
    do_reset(1'b0);
    p0 = pops;
    for (int c = 0; c < 600; c++) begin
      BitIn = 1'($urandom_range(0, 1));
      BitInValid = ($urandom_range(0, 3) != 0);
      SymReady = ($urandom_range(0, 9) < 7);
      step();
    end
    SymReady = 1'b1;
    n = 0;
    while (nbits != 0 && n < 40) begin
      BitInValid = 1'b1;
      BitIn = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    BitInValid = 1'b0;
    drain(40);
    step();
    chk("rand_idle", 32'(Busy), 0);
    chk("rand_pops", 32'(pops - p0 > 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qam32_map_ctrl.md
# qam32_map_ctrl

Sequencing controller for the dual-port 32QAM constellation ROM in the OTFS transmit path. It packs a serial bit stream into 5-bit symbol indices and drives the ROM real-part port (address 0..31) and imaginary-part port (address 32..63). It absorbs the ROM read latency and buffers the resulting 12-bit Re/Im samples in a small output FIFO under valid/ready backpressure. It also tags each frame's last symbol for the downstream OTFS grid writer.

## Interface
Parameters:
- DATA_W, 12: ROM sample width (two's complement).
- ROM_LAT, 1: cycles from address edge to valid ROM data; legal range 1..3.
- FIFO_DEPTH, 4: output buffer entries; must be a power of two and ≥ ROM_LAT+1.
- FRAME_SYMS, 64: symbols per OTFS frame (M×N); legal range 2..4096.

Ports:
- Clk, in, 1: single clock; all logic is on the rising edge.
- Rst_n, in, 1: asynchronous, active-low reset.
- BitIn, in, 1: serial data bit, MSB of each symbol first.
- BitInValid, in, 1: BitIn is valid this cycle.
- BitInReady, out, 1: controller accepts BitIn this cycle.
- RomAddrRe, out, 6: registered ROM port-A address, {1'b0, idx}.
- RomAddrIm, out, 6: registered ROM port-B address, {1'b1, idx} (idx+32).
- RomDoutRe, in, DATA_W: ROM port-A data.
- RomDoutIm, in, DATA_W: ROM port-B data.
- SymRe, out, DATA_W: FIFO head, real part.
- SymIm, out, DATA_W: FIFO head, imaginary part.
- SymValid, out, 1: FIFO is non-empty.
- SymReady, in, 1: consumer takes the head this cycle.
- SymLast, out, 1: head is symbol FRAME_SYMS-1 of the frame.
- Busy, out, 1: any bit, group, in-flight read or FIFO entry is held.

## Operation
- **Bit packing:** a bit transfers when BitInValid && BitInReady. Transferred bits shift into a 5-bit register, MSB first, and a 3-bit BitCnt counts 0..4.
- **Issue:** on the 5th transfer, if credit is available, the completed index loads into RomAddrRe/Im on the same edge and an in-flight tag enters a ROM_LAT-deep valid/last shift pipe. If credit is not available, the index is held in a Pending register and BitInReady goes low.
- **Credit:** credit exists when FIFO occupancy + in-flight count < FIFO_DEPTH. A FIFO pop in the same cycle is not credited.
- **Pending state:** a Pending index issues on the first cycle credit appears. BitInReady = !Pending.
- **Capture:** when a tag exits the pipe, RomDoutRe/Im and the last flag are written to the FIFO. Overflow cannot occur by construction; an overflow is an assertion failure.
- **Address hold:** RomAddrRe/Im hold their last value when no issue occurs.
- **Frame counter:** SymIdx counts 0..FRAME_SYMS-1 per issued symbol and wraps to 0. Last flag = (SymIdx == FRAME_SYMS-1).
- **FIFO:** first-word-fall-through. Push and pop may occur in the same cycle, including when full (after the pop frees an entry) and when empty with no data.
- **States:**
  - COLLECT: BitCnt < 5 and not Pending.
  - STALL: Pending.
  - COLLECT → STALL on the 5th bit without credit; STALL → COLLECT when the held index issues.

## Timing
- Reset values: BitInReady 1; RomAddrRe 0; RomAddrIm 32; SymRe 0; SymIm 0; SymValid 0; SymLast 0; Busy 0. BitCnt, SymIdx, Pending, pipe and FIFO pointers are cleared.
- **Reset mid-operation:** partial groups, in-flight reads and FIFO contents are discarded, and the frame restarts at SymIdx 0.
- **Latency:** SymValid rises ROM_LAT+1 cycles after the edge accepting the 5th bit, given an empty FIFO and available credit.
- **Throughput:** one symbol per 5 accepted bits, with no bubbles while credit is available.
- SymRe, SymIm and SymLast are stable while SymValid && !SymReady.

## Configuration
- QAM32_MAP_FLUSH_EN defined:
  - Adds input BitInLast (1 bit, qualified by the BitIn transfer).
  - A transfer with BitInLast completes the current group immediately. Missing LSBs are zero-padded, the group issues or pends as normal, and BitCnt returns to 0.
- QAM32_MAP_FLUSH_EN undefined:
  - The BitInLast port does not exist.
  - Groups complete only on the 5th bit.

## Structure
- Package qam32_map_pkg holds:
  - BITS_PER_SYM = 5.
  - IM_ADDR_OFFSET = 32.
  - The default DATA_W.
  - The state enum {COLLECT, STALL}.
- Sub-module qam32_sym_fifo: parameterised FWFT FIFO, width 2·DATA_W+1 (Re, Im, last), with a count output used for credit.

## Test plan
- **Basic mapping:** bits 00000 then 11111 back-to-back, with a behavioural ROM model (ROM_LAT=1) and SymReady=1.
  - Addresses 0/32, then 31/63.
  - Symbols equal the ROM entries, SymValid rises 2 cycles after each 5th bit.
- **Backpressure:** SymReady=0 for 40 cycles while 50 bits are offered.
  - FIFO reaches 4 entries and BitInReady drops.
  - After release, all 10 symbols arrive in order with none lost or duplicated.
- **Frame tagging:** FRAME_SYMS=8, 16 symbols streamed → SymLast high on symbols 7 and 15 only; SymIdx wraps.
- **Full FIFO push/pop:** with the FIFO full and Pending set, pulse SymReady for 1 cycle.
  - Exactly one entry is popped.
  - The pending index issues on the next cycle.
  - Occupancy returns to 4 with ordering preserved.
- **Reset mid-group:** assert Rst_n low after 3 bits of a group and while 2 symbols are queued.
  - All outputs take their reset values.
  - The next 5 bits 10101 give address 21/53 and SymIdx 0.
- **Flush (QAM32_MAP_FLUSH_EN):** bits 1, 1 with BitInLast on the 2nd → index 11000 = 24, addresses 24/56, next group starts fresh.
